// File: rtl/bnb_pkg.sv
// Shared constants and elaboration-time parameter checks for the bnb delay-pair block.
//   BNB_RST_VAL      : per-bit value every stage is cleared to
//   BNB_MIN_WIDTH    : smallest legal data width
//   BNB_MIN_DEPTH    : smallest legal nonblocking pipeline depth
//   bnb_params_ok()  : returns 1 when a WIDTH/DEPTH pair is legal
package bnb_pkg;

  localparam logic        BNB_RST_VAL   = 1'b0;
  localparam int unsigned BNB_MIN_WIDTH = 1;
  localparam int unsigned BNB_MIN_DEPTH = 1;

  function automatic bit bnb_params_ok(input int unsigned width, input int unsigned depth);
    return (width >= BNB_MIN_WIDTH) && (depth >= BNB_MIN_DEPTH);
  endfunction

endpackage

// File: rtl/bnb_dff_stage.sv
// Single WIDTH-bit D flip-flop with asynchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous clear, active-low
//   d     : data captured on rising clk
//   q     : registered data
module bnb_dff_stage
  import bnb_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage element; clear wins over clock at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {WIDTH{BNB_RST_VAL}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/bnb_delay_pair.sv
// Two delay paths on one input, used as a latency/ordering reference.
//   clk        : rising-edge clock
//   rst_n      : asynchronous reset, active-low; clears every stage
//   d          : data input
//   q_block    : d delayed 1 cycle (collapsed chain, all stages load d)
//   q_nonblock : d delayed DEPTH cycles (true shift register)
module bnb_delay_pair
  import bnb_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_block,
  output logic [WIDTH-1:0] q_nonblock
);

  // Reject illegal parameterisations at elaboration.
  if (!bnb_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("bnb_delay_pair: WIDTH (%0d) and DEPTH (%0d) must both be >= 1", WIDTH, DEPTH);
  end

  logic [WIDTH-1:0] nb_stage  [DEPTH];
  logic [WIDTH-1:0] blk_stage [DEPTH];

  // Shift register: stage 0 takes d, each later stage takes its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_nb
    if (i == 0) begin : g_head
      bnb_dff_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (nb_stage[i])
      );
    end else begin : g_tail
      bnb_dff_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nb_stage[i-1]),
        .q     (nb_stage[i])
      );
    end
  end

  // Collapsed chain: every stage samples d directly, so all hold the same value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_blk
    bnb_dff_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .q     (blk_stage[i])
    );
  end

  // Collapsed stages must never disagree with the one driving q_block.
  for (genvar i = 0; i + 1 < DEPTH; i++) begin : g_blk_chk
    a_blk_equal : assert property (@(posedge clk) disable iff (!rst_n)
      blk_stage[i] === blk_stage[DEPTH-1]);
  end

  assign q_block    = blk_stage[DEPTH-1];
  assign q_nonblock = nb_stage[DEPTH-1];

endmodule

// File: tb/tb_bnb_delay_pair.sv
// Self-checking bench for bnb_delay_pair: three instances (1x2, 8x4, 4x1)
// compared every cycle against a per-instance history of captured inputs.
module tb_bnb_delay_pair;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic [7:0] d8;
  logic [3:0] d4;

  logic       qb1, qn1;
  logic [7:0] qb8, qn8;
  logic [3:0] qb4, qn4;

  int tests;
  int fails;

  // Values accepted at each rising edge since the last reset, oldest first.
  logic [7:0] h1 [$];
  logic [7:0] h8 [$];
  logic [7:0] h4 [$];

  assign d4 = d8[3:0];

  bnb_delay_pair #(.WIDTH(1), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .d(d1), .q_block(qb1), .q_nonblock(qn1)
  );

  bnb_delay_pair #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .d(d8), .q_block(qb8), .q_nonblock(qn8)
  );

  bnb_delay_pair #(.WIDTH(4), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .d(d4), .q_block(qb4), .q_nonblock(qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output k cycles after capture: the k-th most recent accepted input, or 0 if not yet filled.
  function automatic logic [7:0] past(input logic [7:0] h [$], input int k);
    if (h.size() < k) return 8'h00;
    return h[h.size() - k];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string phase);
    check({phase, ".d2.q_block"},    {7'd0, qb1}, past(h1, 1));
    check({phase, ".d2.q_nonblock"}, {7'd0, qn1}, past(h1, 2));
    check({phase, ".d4.q_block"},    qb8,         past(h8, 1));
    check({phase, ".d4.q_nonblock"}, qn8,         past(h8, 4));
    check({phase, ".d1.q_block"},    {4'd0, qb4}, past(h4, 1));
    check({phase, ".d1.q_nonblock"}, {4'd0, qn4}, past(h4, 1));
    check({phase, ".d1.same"},       {4'd0, qn4}, {4'd0, qb4});
  endtask

  // One cycle: update reset/d mid-cycle, then let an edge happen and check after it.
  task automatic tick(input string phase, input logic rst, input logic v1, input logic [7:0] v8);
    @(negedge clk);
    if (!rst && rst_n) begin
      rst_n = 1'b0;
      h1.delete();
      h8.delete();
      h4.delete();
      #1;
      check({phase, ".async.d2.qb"}, {7'd0, qb1}, 8'h00);
      check({phase, ".async.d2.qn"}, {7'd0, qn1}, 8'h00);
      check({phase, ".async.d4.qb"}, qb8,         8'h00);
      check({phase, ".async.d4.qn"}, qn8,         8'h00);
      check({phase, ".async.d1.qn"}, {4'd0, qn4}, 8'h00);
    end else begin
      rst_n = rst;
    end
    d1 = v1;
    d8 = v8;
    @(posedge clk);
    if (rst_n) begin
      h1.push_back({7'd0, d1});
      h8.push_back(d8);
      h4.push_back({4'd0, d4});
    end
    #1;
    check_all(phase);
  endtask

  initial begin
    logic [7:0] r;
    logic [4:0] toggle;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    d1     = 1'b1;
    d8     = 8'hFF;
    toggle = 5'b01101;

    // Reset held with d=1: everything stays cleared.
    for (int i = 0; i < 3; i++) tick("reset", 1'b0, 1'b1, 8'hFF);

    // Release, then steady zero.
    for (int i = 0; i < 7; i++) tick("zero", 1'b1, 1'b0, 8'h00);

    // Single pulse, then drain.
    tick("pulse", 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 5; i++) tick("pulse", 1'b1, 1'b0, 8'h00);

    // Toggle pattern 1,0,1,1,0 (LSB first), random wide data alongside.
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      tick("toggle", 1'b1, toggle[i], r);
    end
    for (int i = 0; i < 4; i++) tick("toggle", 1'b1, 1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      r = 8'($urandom);
      tick("rand", 1'b1, 1'($urandom_range(0, 1)), r);
    end

    // Fill with ones, then reset between edges; nothing stale after release.
    for (int i = 0; i < 5; i++) tick("fill", 1'b1, 1'b1, 8'hFF);
    tick("midrst", 1'b0, 1'b1, 8'hFF);
    tick("midrst", 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 6; i++) tick("refill", 1'b1, 1'b1, 8'h3C);

    // More random traffic after the mid-stream reset.
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom);
      tick("rand2", 1'b1, 1'($urandom_range(0, 1)), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
